clk_period_meter: RTL and testbench
===================================

# clk_period_meter

Measures an asynchronous slow clock, such as the output of the team's clock divider, in units of I_CLK cycles. It synchronizes the input and detects rising edges. Each edge-to-edge interval is reported as a period count with a one-cycle valid strobe, and lock and timeout status are flagged. It sits on the consumer side of any divided or external clock so the divider ratio can be checked in-system.

## Interface
- CNT_W, 16: width of the period and high-time counters.
- TOL, 1: maximum allowed |period − previous period| for a measurement to count as matching.
- LOCK_N, 4: consecutive matching measurements required to assert O_LOCK.
- I_CLK  input  1  measurement clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset; clears all state immediately.
- I_SIG  input  1  clock under measurement; asynchronous to I_CLK.
- O_PERIOD  output  CNT_W  last measured period in I_CLK cycles.
- O_HIGH  output  CNT_W  I_CLK cycles I_SIG was high within the last period (see Configuration).
- O_VALID  output  1  one-cycle pulse when O_PERIOD/O_HIGH update.
- O_LOCK  output  1  period stable within TOL for LOCK_N consecutive comparisons.
- O_TIMEOUT  output  1  counter saturated with no edge; sticky until next rising edge.

## Operation
- Synchronizer: s1 <= I_SIG, s2 <= s1, s3 <= s2. rise = s2 & ~s3 is combinational.
- States: IDLE, MEASURE.
  - IDLE: the counter is held at 0. On rise, load cnt = 1 and go to MEASURE. No O_VALID is produced on this first edge.
  - MEASURE, no rise: cnt <= cnt + 1.
  - MEASURE, rise: O_PERIOD <= cnt, O_VALID <= 1, cnt <= 1. Stay in MEASURE. An input with a rise every N I_CLK cycles yields O_PERIOD = N.
  - MEASURE, cnt == 2^CNT_W − 1 with no rise: go to IDLE, O_TIMEOUT <= 1, O_LOCK <= 0, match count <= 0, O_PERIOD <= 0. No O_VALID.
  - Rise and saturation in the same cycle: rise wins, and O_PERIOD = 2^CNT_W − 1.
- Lock logic:
  - The previous period is stored on each O_VALID.
  - The first measurement after IDLE has no predecessor and does not update the match count.
  - Each later measurement: if |new − prev| <= TOL, match count increments, saturating at LOCK_N. Otherwise match count <= 0 and O_LOCK <= 0.
  - O_LOCK <= 1 when match count reaches LOCK_N.
  - The difference is computed unsigned-safe, as the larger minus the smaller.
- O_TIMEOUT clears on the next rise seen in IDLE.
- Minimum supported input: high and low phases each >= 2 I_CLK cycles, so period >= 4. Behaviour for shorter phases is undefined.

## Timing
- Reset values: O_PERIOD = 0, O_HIGH = 0, O_VALID = 0, O_LOCK = 0, O_TIMEOUT = 0, state = IDLE, s1/s2/s3 = 0.
- I_SIG rising to O_VALID: 3 I_CLK rising edges (2 synchronizer stages plus the output register). Synchronizer uncertainty adds ±1 cycle, so an individual O_PERIOD may deviate by ±1 from the true ratio.
- O_VALID is high for exactly one cycle per measured edge. O_PERIOD and O_HIGH hold their values between pulses.
- O_LOCK changes only in the cycle O_VALID asserts, or on timeout.
- rst assertion mid-measurement: all outputs return to reset values within the same cycle. After release, the first O_VALID arrives on the second detected rise.

## Configuration
- PERIOD_METER_DUTY_EN defined:
  - A high-time counter hcnt is loaded to 1 on rise and increments each MEASURE cycle with s2 = 1, saturating at 2^CNT_W − 1.
  - On rise, O_HIGH <= hcnt, updated alongside O_PERIOD. Cleared on timeout.
- PERIOD_METER_DUTY_EN undefined: O_HIGH is constant 0 and no hcnt logic is built.

## Test plan
- Period check: I_CLK 10 ns, I_SIG period 100 ns at 50% duty, from a divider-by-10 → O_PERIOD = 10 on every O_VALID, ±1 allowed. With DUTY_EN, O_HIGH = 5 ±1. O_LOCK rises on the 5th O_VALID (LOCK_N = 4).
- Ratio step: I_SIG changes from period 10 to period 16 → the next O_VALID reports 16, O_LOCK drops in that same cycle, and O_LOCK reasserts after 4 further matching measurements.
- Timeout: CNT_W = 8, stop I_SIG low → after 255 MEASURE cycles, O_TIMEOUT = 1, O_LOCK = 0, O_PERIOD = 0, and no O_VALID. Restarting I_SIG clears O_TIMEOUT on the first rise; the first new O_VALID comes on the second rise.
- Reset: drive rst low mid-period while locked → all outputs go to 0 asynchronously. After rst returns high, no O_VALID until two rises have been observed.
- Jitter tolerance: alternate periods 10, 11, 10, 11 with TOL = 1 → O_LOCK asserts. With TOL = 0, O_LOCK stays 0.
- Without PERIOD_METER_DUTY_EN: repeat the first scenario → O_HIGH stays 0 and O_PERIOD behaviour is unchanged.

Source files
------------

// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
//
// Measures the period of an asynchronous slow clock (I_SIG) in units of I_CLK
// cycles. I_SIG passes through a two-stage synchronizer, and a third flop
// detects its rising edges. Each edge-to-edge interval is reported on O_PERIOD
// together with a one-cycle O_VALID strobe. O_LOCK reports a stable ratio, and
// O_TIMEOUT reports a stalled input (the counter saturated with no edge).
//
// Optional feature (compile-time macro PERIOD_METER_DUTY_EN):
//   defined   - a high-time counter reports the I_CLK cycles I_SIG was high
//               during the last period on O_HIGH.
//   undefined - O_HIGH is tied to 0 and no high-time logic is built.
//
// Parameters:
//   CNT_W   width of the period and high-time counters
//   TOL     maximum |period - previous period| that still counts as a match
//   LOCK_N  consecutive matching measurements required for O_LOCK
//
// Ports:
//   I_CLK      in   measurement clock; all state changes on its rising edge
//   rst        in   asynchronous active-low reset
//   I_SIG      in   clock under measurement, asynchronous to I_CLK
//   O_PERIOD   out  last measured period in I_CLK cycles
//   O_HIGH     out  I_CLK cycles I_SIG was high within the last period
//   O_VALID    out  one-cycle pulse when O_PERIOD/O_HIGH update
//   O_LOCK     out  period stable within TOL for LOCK_N comparisons
//   O_TIMEOUT  out  counter saturated with no edge; sticky until next rise
// -----------------------------------------------------------------------------
module clk_period_meter #(
  parameter int CNT_W  = 16,
  parameter int TOL    = 1,
  parameter int LOCK_N = 4
) (
  input  logic             I_CLK,
  input  logic             rst,
  input  logic             I_SIG,
  output logic [CNT_W-1:0] O_PERIOD,
  output logic [CNT_W-1:0] O_HIGH,
  output logic             O_VALID,
  output logic             O_LOCK,
  output logic             O_TIMEOUT
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TOL_V    = CNT_W'(TOL);
  localparam int               MW       = $clog2(LOCK_N + 1);
  localparam logic [MW-1:0]    LOCK_MAX = MW'(LOCK_N);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_e;

  // Synchronizer and edge detector
  logic s1_q, s2_q, s3_q;
  logic rise;

  // Measurement state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic [MW-1:0]    match_q, match_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             lock_q, lock_d;
  logic             timeout_q, timeout_d;

  logic [CNT_W-1:0] diff;
  logic [MW-1:0]    match_inc;
  logic             sat;

  // The third stage only delays s2 for edge detection; it is never treated as
  // a level by the measurement logic.
  assign rise = s2_q & ~s3_q;

  // Counter has reached its maximum in MEASURE with no edge to end the period.
  assign sat = (state_q == MEASURE) && !rise && (cnt_q == CNT_MAX);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    match_d     = match_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    lock_d      = lock_q;
    timeout_d   = timeout_q;

    // Unsigned-safe distance: larger minus smaller.
    diff      = (cnt_q >= prev_q) ? (cnt_q - prev_q) : (prev_q - cnt_q);
    match_inc = (match_q == LOCK_MAX) ? match_q : (match_q + MW'(1));

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise) begin
          // First edge only opens the measurement window; there is no
          // interval to report yet.
          state_d     = MEASURE;
          cnt_d       = CNT_ONE;
          timeout_d   = 1'b0;
          have_prev_d = 1'b0;
        end
      end

      MEASURE: begin
        if (rise) begin
          // A rise wins over saturation, so a full-scale period is reported.
          period_d    = cnt_q;
          valid_d     = 1'b1;
          cnt_d       = CNT_ONE;
          prev_d      = cnt_q;
          have_prev_d = 1'b1;
          if (have_prev_q) begin
            if (diff <= TOL_V) begin
              match_d = match_inc;
              if (match_inc == LOCK_MAX) lock_d = 1'b1;
            end else begin
              match_d = '0;
              lock_d  = 1'b0;
            end
          end
        end else if (sat) begin
          state_d     = IDLE;
          cnt_d       = '0;
          timeout_d   = 1'b1;
          lock_d      = 1'b0;
          match_d     = '0;
          period_d    = '0;
          have_prev_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge rst) begin
    if (!rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      match_q     <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      lock_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, which is what lets the synchronizer chain shift by one stage.
      s1_q        <= I_SIG;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      match_q     <= match_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      lock_q      <= lock_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;

  // High time is counted on the synchronized level s2. The rise cycle itself
  // is the first high cycle, hence the load value of 1.
  always_comb begin
    hcnt_d = hcnt_q;
    high_d = high_q;
    if (state_q == IDLE) begin
      if (rise) hcnt_d = CNT_ONE;
    end else if (rise) begin
      high_d = hcnt_q;
      hcnt_d = CNT_ONE;
    end else if (sat) begin
      high_d = '0;
      hcnt_d = '0;
    end else if (s2_q && (hcnt_q != CNT_MAX)) begin
      hcnt_d = hcnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge I_CLK or negedge rst) begin
    if (!rst) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      high_q <= high_d;
    end
  end

  assign O_HIGH = high_q;
`else
  assign O_HIGH = '0;
`endif

  assign O_PERIOD  = period_q;
  assign O_VALID   = valid_q;
  assign O_LOCK    = lock_q;
  assign O_TIMEOUT = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// -----------------------------------------------------------------------------
// tb_clk_period_meter
//
// Two meters (TOL = 1 and TOL = 0, CNT_W = 8) watch the same I_SIG. I_SIG is
// driven on falling I_CLK edges, so every rise is seen deterministically and
// periods are exact. A timestamp-based model derives the expected outputs:
// a rise sampled at edge k is acted on at edge k+2; a period is the distance
// between two acted-on rises; the high time is the number of high samples in
// that window. A compare process checks both meters every cycle, and directed
// literal checks pin the model at the points of interest.
// -----------------------------------------------------------------------------
module tb_clk_period_meter;

  localparam int CW    = 8;
  localparam int MAXV  = (1 << CW) - 1;
  localparam int LN    = 4;
  localparam int HSIZE = 16384;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sig = 1'b0;

  logic [CW-1:0] per_a, high_a, per_b, high_b;
  logic          val_a, lock_a, to_a, val_b, lock_b, to_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_period_meter #(.CNT_W(CW), .TOL(1), .LOCK_N(LN)) dut_a (
    .I_CLK(clk), .rst(rst), .I_SIG(sig),
    .O_PERIOD(per_a), .O_HIGH(high_a), .O_VALID(val_a),
    .O_LOCK(lock_a), .O_TIMEOUT(to_a)
  );

  clk_period_meter #(.CNT_W(CW), .TOL(0), .LOCK_N(LN)) dut_b (
    .I_CLK(clk), .rst(rst), .I_SIG(sig),
    .O_PERIOD(per_b), .O_HIGH(high_b), .O_VALID(val_b),
    .O_LOCK(lock_b), .O_TIMEOUT(to_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit meas;       // a first rise has been seen, an interval is open
    int last;       // edge index of the rise that opened the interval
    bit have_prev;
    int prev;
    int match;
    int period;
    int high;
    bit valid;
    bit lock;
    bit timeout;
  } model_t;

  localparam model_t M_RESET = '{default: 0};

  bit     samp [HSIZE];   // I_SIG as captured by the first flop at each edge
  int     n = 0;          // edge index
  model_t m [2];
  int     tol_of [2] = '{1, 0};

  function automatic model_t step(input model_t s, input int nn, input int tol);
    bit rise;
    int p, h, d;
    rise    = (nn >= 3) && samp[nn-2] && !samp[nn-3];
    s.valid = 1'b0;
    if (!s.meas) begin
      if (rise) begin
        s.meas      = 1'b1;
        s.last      = nn;
        s.timeout   = 1'b0;
        s.have_prev = 1'b0;
      end
    end else if (rise) begin
      p = nn - s.last;
      h = 0;
      for (int e = s.last; e < nn; e++) h += int'(samp[e-2]);
      if (h > MAXV) h = MAXV;
      s.period = p;
      s.high   = h;
      s.valid  = 1'b1;
      if (s.have_prev) begin
        d = (p > s.prev) ? p - s.prev : s.prev - p;
        if (d <= tol) begin
          if (s.match < LN) s.match++;
          if (s.match == LN) s.lock = 1'b1;
        end else begin
          s.match = 0;
          s.lock  = 1'b0;
        end
      end
      s.prev      = p;
      s.have_prev = 1'b1;
      s.last      = nn;
    end else if (nn - s.last == MAXV) begin
      s.meas      = 1'b0;
      s.timeout   = 1'b1;
      s.lock      = 1'b0;
      s.match     = 0;
      s.period    = 0;
      s.high      = 0;
      s.have_prev = 1'b0;
    end
    return s;
  endfunction

  initial begin
    m[0] = M_RESET;
    m[1] = M_RESET;
  end

  always @(posedge clk) begin
    if (n >= HSIZE) begin
      $display("FAIL history_bound: edge %0d exceeds %0d", n, HSIZE);
      $fatal(1, "history overflow");
    end
    if (!rst) begin
      samp[n] = 1'b0;
      m[0]    = M_RESET;
      m[1]    = M_RESET;
    end else begin
      samp[n] = sig;
      for (int k = 0; k < 2; k++) m[k] = step(m[k], n, tol_of[k]);
    end
    n++;
  end

  // ---------------------------------------------------------------------------
  // Compare process and record of dut_a measurements
  // ---------------------------------------------------------------------------
  int vcnt = 0;
  int vper  [64];
  int vlock [64];

  function automatic int pack(input int p, input int h, input bit v,
                              input bit l, input bit t);
    return (p << 11) | (h << 3) | (int'(v) << 2) | (int'(l) << 1) | int'(t);
  endfunction

  function automatic int expected(input model_t s);
    int h;
`ifdef PERIOD_METER_DUTY_EN
    h = s.high;
`else
    h = 0;
`endif
    if (!rst) return 0;
    return pack(s.period, h, s.valid, s.lock, s.timeout);
  endfunction

  always @(negedge clk) begin
    check("dut_a {period,high,valid,lock,timeout}",
          pack(int'(per_a), int'(high_a), val_a, lock_a, to_a), expected(m[0]));
    check("dut_b {period,high,valid,lock,timeout}",
          pack(int'(per_b), int'(high_b), val_b, lock_b, to_b), expected(m[1]));
    if (val_a && vcnt < 63) begin
      vcnt++;
      vper[vcnt]  = int'(per_a);
      vlock[vcnt] = int'(lock_a);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // Entered just after a falling edge; one full period of I_SIG.
  task automatic pulse(input int per, input int hi);
    sig = 1'b1;
    repeat (hi) @(negedge clk);
    sig = 1'b0;
    repeat (per - hi) @(negedge clk);
  endtask

  // Step past the compare process before reading the measurement record.
  task automatic settle();
    #1;
  endtask

  int v0;

  initial begin
    repeat (3) @(negedge clk);
    settle();
    check("reset period", int'(per_a), 0);
    check("reset valid", int'(val_a), 0);
    check("reset lock", int'(lock_a), 0);
    check("reset timeout", int'(to_a), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Divide-by-10 input, 50 % duty: 8 rises give 7 measurements.
    repeat (8) pulse(10, 5);
    settle();
    check("div10 measurement count", vcnt, 7);
    check("div10 2nd period", vper[2], 10);
    check("div10 lock before 5th valid", vlock[4], 0);
    check("div10 lock on 5th valid", vlock[5], 1);

    // Ratio step 10 -> 16: the 8th measurement still spans 10 cycles.
    repeat (8) pulse(16, 8);
    settle();
    check("step measurement count", vcnt, 15);
    check("step lock kept on last 10", vlock[8], 1);
    check("step first 16 period", vper[9], 16);
    check("step lock drops on first 16", vlock[9], 0);
    check("step lock after 3 matches", vlock[12], 0);
    check("step lock after 4 matches", vlock[13], 1);

    // Stall: counter saturates after 255 cycles.
    repeat (300) @(negedge clk);
    settle();
    check("timeout flag", int'(to_a), 1);
    check("timeout period", int'(per_a), 0);
    check("timeout lock", int'(lock_a), 0);
    check("timeout high", int'(high_a), 0);
    check("timeout no valid", vcnt, 15);

    // Restart: first rise clears timeout, second rise yields a measurement.
    pulse(10, 5);
    settle();
    check("restart timeout cleared", int'(to_a), 0);
    check("restart no valid on first rise", vcnt, 15);
    pulse(10, 5);
    settle();
    check("restart valid on second rise", vcnt, 16);
    check("restart period", vper[16], 10);

    // Jitter 10/11: locks with TOL = 1, never with TOL = 0.
    repeat (6) begin
      pulse(10, 5);
      pulse(11, 5);
    end
    settle();
    check("jitter lock TOL=1", int'(lock_a), 1);
    check("jitter lock TOL=0", int'(lock_b), 0);

    // Asynchronous reset mid-period while locked.
    sig = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async reset period", int'(per_a), 0);
    check("async reset lock", int'(lock_a), 0);
    check("async reset valid", int'(val_a), 0);
    check("async reset timeout", int'(to_a), 0);
    check("async reset high", int'(high_a), 0);
    sig = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    settle();
    v0 = vcnt;
    pulse(10, 5);
    settle();
    check("post-reset no valid on first rise", vcnt, v0);
    pulse(10, 5);
    settle();
    check("post-reset valid on second rise", vcnt, v0 + 1);
    check("post-reset period", vper[v0 + 1], 10);
    check("post-reset lock", int'(lock_a), 0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
